// File: rtl/key_event_detector.sv
// key_event_detector: multi-channel push-button front end.
// Each channel has a 2-FF synchroniser and a debounce / long-press FSM. The FSM
// produces a debounced level and one-cycle press, release, long and repeat pulses.
// All outputs are registered.
// Optional feature: define KEY_DETECTOR_REPEAT_EN to enable auto-repeat pulses
// while a key is long-held. When it is undefined, key_repeat is tied to 0.
// state_dbg exposes each channel's FSM state (channel i in state_dbg[i]).
// Handshake: none. Inputs are free-running pins and outputs are single-cycle
// strobes, so no valid/ready pairing is involved.

module key_event_detector #(
   parameter int KEY_NUM       = 3,
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter int DEB_CYCLES    = 1_000_000,
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 15_000_000,
   parameter int CNT_W         = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [KEY_NUM-1:0]      key_in,
   output logic [KEY_NUM-1:0]      key_level,
   output logic [KEY_NUM-1:0]      key_press,
   output logic [KEY_NUM-1:0]      key_release,
   output logic [KEY_NUM-1:0]      key_long,
   output logic [KEY_NUM-1:0]      key_repeat,
   output logic                    key_any,
   output logic [KEY_NUM-1:0][2:0] state_dbg
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DEB_DN   = 3'd1,
      ST_PRESSED  = 3'd2,
      ST_LONGHELD = 3'd3,
      ST_DEB_UP   = 3'd4
   } state_t;

   localparam longint CNT_LIMIT = longint'(1) << CNT_W;

   // Reject configurations whose counters could never reach their terminal count.
   if (DEB_CYCLES < 1 || LONG_CYCLES < 1 ||
       longint'(DEB_CYCLES) >= CNT_LIMIT || longint'(LONG_CYCLES) >= CNT_LIMIT ||
       longint'(REPEAT_CYCLES) >= CNT_LIMIT) begin : g_param_err
      $error("key_event_detector: *_CYCLES out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_DETECTOR_REPEAT_EN
   if (REPEAT_CYCLES < 1) begin : g_rep_err
      $error("key_event_detector: REPEAT_CYCLES must be >= 1");
   end
   localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);
`else
   assign key_repeat = '0;
`endif

   // Raw level of a released key; the synchroniser resets to it so that no press
   // is seen while reset is asserted.
   localparam logic [KEY_NUM-1:0] IDLE_LVL = {KEY_NUM{ACTIVE_LOW}};

   logic [KEY_NUM-1:0] sync1, sync2, p_vec, level_d;

   // Two-flop synchroniser and the registered any-key flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= IDLE_LVL;
         sync2   <= IDLE_LVL;
         key_any <= 1'b0;
      end else begin
         sync1   <= key_in;
         sync2   <= sync1;
         key_any <= |level_d;
      end
   end

   // p_vec[i] = 1 means channel i is pressed, whatever the pin polarity.
   assign p_vec = sync2 ^ IDLE_LVL;

   for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
      state_t           state, state_nx;
      logic [CNT_W-1:0] cnt, cnt_nx;
      logic             long_flag, long_flag_nx;
      logic             level_q, press_q, release_q, long_q;
      logic             level_nx, press_nx, release_nx, long_nx;
      logic             p, deb_tc, long_tc;

      assign p       = p_vec[i];
      assign deb_tc  = (cnt == DEB_TC);
      assign long_tc = (cnt == LONG_TC);

`ifdef KEY_DETECTOR_REPEAT_EN
      logic repeat_q, repeat_nx, rep_tc;
      assign rep_tc        = (cnt == REP_TC);
      assign key_repeat[i] = repeat_q;
`endif

      // State, counter, long flag and registered outputs.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            long_flag <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
`ifdef KEY_DETECTOR_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
         end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            long_flag <= long_flag_nx;
            level_q   <= level_nx;
            press_q   <= press_nx;
            release_q <= release_nx;
            long_q    <= long_nx;
`ifdef KEY_DETECTOR_REPEAT_EN
            repeat_q  <= repeat_nx;
`endif
         end
      end

      // Next state and counter. Every counting path leaves at its terminal count,
      // so the counter never wraps.
      always_comb begin
         state_nx     = state;
         cnt_nx       = cnt;
         long_flag_nx = long_flag;
         case (state)
            ST_IDLE: begin
               cnt_nx = '0;
               if (p) state_nx = ST_DEB_DN;
            end
            ST_DEB_DN: begin
               if (!p) begin
                  state_nx = ST_IDLE;
                  cnt_nx   = '0;
               end else if (deb_tc) begin
                  state_nx = ST_PRESSED;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx   = cnt + CNT_ONE;
               end
            end
            ST_PRESSED: begin
               if (!p) begin
                  state_nx = ST_DEB_UP;
                  cnt_nx   = '0;
               end else if (long_tc) begin
                  state_nx     = ST_LONGHELD;
                  cnt_nx       = '0;
                  long_flag_nx = 1'b1;
               end else begin
                  cnt_nx   = cnt + CNT_ONE;
               end
            end
            ST_LONGHELD: begin
               if (!p) begin
                  state_nx = ST_DEB_UP;
                  cnt_nx   = '0;
               end
`ifdef KEY_DETECTOR_REPEAT_EN
               else if (rep_tc) cnt_nx = '0;
               else             cnt_nx = cnt + CNT_ONE;
`endif
            end
            ST_DEB_UP: begin
               if (p) begin
                  // A bounce during release resumes the hold. The long flag keeps
                  // key_long from firing a second time for the same press.
                  state_nx = long_flag ? ST_LONGHELD : ST_PRESSED;
                  cnt_nx   = '0;
               end else if (deb_tc) begin
                  state_nx     = ST_IDLE;
                  cnt_nx       = '0;
                  long_flag_nx = 1'b0;
               end else begin
                  cnt_nx   = cnt + CNT_ONE;
               end
            end
            default: begin
               state_nx     = ST_IDLE;
               cnt_nx       = '0;
               long_flag_nx = 1'b0;
            end
         endcase
      end

      // Next output values. Level covers every held state, including DEB_UP.
      always_comb begin
         level_nx   = (state_nx == ST_PRESSED) || (state_nx == ST_LONGHELD) ||
                      (state_nx == ST_DEB_UP);
         press_nx   = (state == ST_DEB_DN)  &&  p && deb_tc;
         release_nx = (state == ST_DEB_UP)  && !p && deb_tc;
         long_nx    = (state == ST_PRESSED) &&  p && long_tc;
`ifdef KEY_DETECTOR_REPEAT_EN
         repeat_nx  = (state == ST_LONGHELD) && p && rep_tc;
`endif
      end

      assign level_d[i]     = level_nx;
      assign key_level[i]   = level_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;
      assign key_long[i]    = long_q;
      assign state_dbg[i]   = state;
   end

endmodule
